// File: rtl/axi_stream_2_to_1_arbiter_if.sv
// AXI-Stream bundle shared by the arbiter inputs and its merged output.
// master drives payload and tvalid; slave drives tready.
interface axi_stream_2_to_1_arbiter_if #(
  parameter int unsigned AXIS_BUS_WIDTH   = 64,
  parameter int unsigned AXIS_TID_WIDTH   = 1,
  parameter int unsigned AXIS_TDEST_WIDTH = 1,
  parameter int unsigned AXIS_TUSER_WIDTH = 1
);
  localparam int unsigned KeepWidth = AXIS_BUS_WIDTH / 8;

  logic [AXIS_BUS_WIDTH-1:0]   tdata;
  logic [KeepWidth-1:0]        tkeep;
  logic [AXIS_TID_WIDTH-1:0]   tid;
  logic [AXIS_TDEST_WIDTH-1:0] tdest;
  logic [AXIS_TUSER_WIDTH-1:0] tuser;
  logic                        tlast;
  logic                        tvalid;
  logic                        tready;

  modport master (
    output tdata, tkeep, tid, tdest, tuser, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tid, tdest, tuser, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/axi_stream_2_to_1_arbiter.sv
// Packet-level 2:1 AXI-Stream arbiter: the grant is held from the first beat of a packet
// until its tlast beat is accepted; ties go to the input not served last.
module axi_stream_2_to_1_arbiter #(
  parameter int unsigned AXIS_BUS_WIDTH   = 64,
  parameter int unsigned AXIS_TID_WIDTH   = 1,
  parameter int unsigned AXIS_TDEST_WIDTH = 1,
  parameter int unsigned AXIS_TUSER_WIDTH = 1
) (
  input logic                         aclk,
  input logic                         aresetn,
  axi_stream_2_to_1_arbiter_if.slave  axis_in_0,
  axi_stream_2_to_1_arbiter_if.slave  axis_in_1,
  axi_stream_2_to_1_arbiter_if.master axis_out
);
  localparam int unsigned KeepWidth = AXIS_BUS_WIDTH / 8;

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                      state_q;
  logic                        grant_q;
  logic                        last_served_q;

  logic [AXIS_BUS_WIDTH-1:0]   out_tdata_q;
  logic [KeepWidth-1:0]        out_tkeep_q;
  logic [AXIS_TID_WIDTH-1:0]   out_tid_q;
  logic [AXIS_TDEST_WIDTH-1:0] out_tdest_q;
  logic [AXIS_TUSER_WIDTH-1:0] out_tuser_q;
  logic                        out_tlast_q;
  logic                        out_tvalid_q;

  logic [AXIS_BUS_WIDTH-1:0]   sel_tdata;
  logic [KeepWidth-1:0]        sel_tkeep;
  logic [AXIS_TID_WIDTH-1:0]   sel_tid;
  logic [AXIS_TDEST_WIDTH-1:0] sel_tdest;
  logic [AXIS_TUSER_WIDTH-1:0] sel_tuser;
  logic                        sel_tlast;
  logic                        sel_tvalid;
  logic                        sel_tready;
  logic                        out_slot_free;
  logic                        sel_fire;

  always_comb begin
    if (grant_q) begin
      sel_tdata  = axis_in_1.tdata;
      sel_tkeep  = axis_in_1.tkeep;
      sel_tid    = axis_in_1.tid;
      sel_tdest  = axis_in_1.tdest;
      sel_tuser  = axis_in_1.tuser;
      sel_tlast  = axis_in_1.tlast;
      sel_tvalid = axis_in_1.tvalid;
    end else begin
      sel_tdata  = axis_in_0.tdata;
      sel_tkeep  = axis_in_0.tkeep;
      sel_tid    = axis_in_0.tid;
      sel_tdest  = axis_in_0.tdest;
      sel_tuser  = axis_in_0.tuser;
      sel_tlast  = axis_in_0.tlast;
      sel_tvalid = axis_in_0.tvalid;
    end
  end

  // The output register can take a new beat when empty or being drained this cycle.
  assign out_slot_free = !out_tvalid_q || axis_out.tready;
  // Gated by aresetn so both inputs are refused for the whole reset window.
  assign sel_tready    = aresetn && (state_q == StLocked) && out_slot_free;
  assign sel_fire      = sel_tvalid && sel_tready;

  assign axis_in_0.tready = sel_tready && !grant_q;
  assign axis_in_1.tready = sel_tready && grant_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= StIdle;
      grant_q       <= 1'b0;
      last_served_q <= 1'b1;
      out_tdata_q   <= '0;
      out_tkeep_q   <= '0;
      out_tid_q     <= '0;
      out_tdest_q   <= '0;
      out_tuser_q   <= '0;
      out_tlast_q   <= 1'b0;
      out_tvalid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (axis_in_0.tvalid || axis_in_1.tvalid) begin
            state_q <= StLocked;
            if (axis_in_0.tvalid && axis_in_1.tvalid) begin
              grant_q <= !last_served_q;
            end else begin
              grant_q <= axis_in_1.tvalid;
            end
          end
        end
        StLocked: begin
          if (sel_fire && sel_tlast) begin
            state_q       <= StIdle;
            last_served_q <= grant_q;
          end
        end
      endcase

      if (out_slot_free) begin
        out_tvalid_q <= (state_q == StLocked) && sel_tvalid;
        out_tdata_q  <= sel_tdata;
        out_tkeep_q  <= sel_tkeep;
        out_tid_q    <= sel_tid;
        out_tdest_q  <= sel_tdest;
        out_tuser_q  <= sel_tuser;
        out_tlast_q  <= sel_tlast;
      end
    end
  end

  assign axis_out.tdata  = out_tdata_q;
  assign axis_out.tkeep  = out_tkeep_q;
  assign axis_out.tid    = out_tid_q;
  assign axis_out.tdest  = out_tdest_q;
  assign axis_out.tuser  = out_tuser_q;
  assign axis_out.tlast  = out_tlast_q;
  assign axis_out.tvalid = out_tvalid_q;
endmodule

// File: tb/tb_axi_stream_2_to_1_arbiter.sv
// Bench for the 2:1 packet arbiter: directed scenarios plus random traffic, scored against a
// packet/queue model of the arbitration rules.
module tb_axi_stream_2_to_1_arbiter;
  localparam int unsigned BW = 32;
  localparam int unsigned KW = BW / 8;
  localparam int unsigned IW = 2;
  localparam int unsigned DW = 2;
  localparam int unsigned UW = 3;

  typedef struct packed {
    logic [BW-1:0] data;
    logic [KW-1:0] keep;
    logic [IW-1:0] id;
    logic [DW-1:0] dest;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi_stream_2_to_1_arbiter_if #(.AXIS_BUS_WIDTH(BW), .AXIS_TID_WIDTH(IW),
    .AXIS_TDEST_WIDTH(DW), .AXIS_TUSER_WIDTH(UW)) in0_if ();
  axi_stream_2_to_1_arbiter_if #(.AXIS_BUS_WIDTH(BW), .AXIS_TID_WIDTH(IW),
    .AXIS_TDEST_WIDTH(DW), .AXIS_TUSER_WIDTH(UW)) in1_if ();
  axi_stream_2_to_1_arbiter_if #(.AXIS_BUS_WIDTH(BW), .AXIS_TID_WIDTH(IW),
    .AXIS_TDEST_WIDTH(DW), .AXIS_TUSER_WIDTH(UW)) out_if ();

  axi_stream_2_to_1_arbiter #(
    .AXIS_BUS_WIDTH  (BW),
    .AXIS_TID_WIDTH  (IW),
    .AXIS_TDEST_WIDTH(DW),
    .AXIS_TUSER_WIDTH(UW)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .axis_in_0(in0_if),
    .axis_in_1(in1_if),
    .axis_out (out_if)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Source state: pending beats, whether the front beat is being offered, gap control.
  beat_t    src0_q[$];
  beat_t    src1_q[$];
  bit [1:0] busy;
  int       hold[2];
  int       gap_at[2];
  int       beat_cnt[2];
  int       p_valid;
  bit       rand_ready;

  // Reference model: free/owner arbitration state and beats accepted but not yet delivered.
  bit       m_free;
  bit       m_last;
  bit       m_owner;
  beat_t    m_q[$];
  bit       prev_stall;
  beat_t    prev_out;
  bit [1:0] acc;
  int       acc_total;
  int       cyc;
  int       pkt_log[$];
  logic [BW-1:0] data_log[$];
  int       fire_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t in_beat(input bit s);
    if (s) return {in1_if.tdata, in1_if.tkeep, in1_if.tid, in1_if.tdest, in1_if.tuser,
                   in1_if.tlast};
    return {in0_if.tdata, in0_if.tkeep, in0_if.tid, in0_if.tdest, in0_if.tuser, in0_if.tlast};
  endfunction

  function automatic beat_t out_beat();
    return {out_if.tdata, out_if.tkeep, out_if.tid, out_if.tdest, out_if.tuser, out_if.tlast};
  endfunction

  task automatic drive(input bit s);
    beat_t b;
    b = '0;
    if (s) begin
      if (src1_q.size() != 0) b = src1_q[0];
      {in1_if.tdata, in1_if.tkeep, in1_if.tid, in1_if.tdest, in1_if.tuser, in1_if.tlast} = b;
      in1_if.tvalid = busy[1];
    end else begin
      if (src0_q.size() != 0) b = src0_q[0];
      {in0_if.tdata, in0_if.tkeep, in0_if.tid, in0_if.tdest, in0_if.tuser, in0_if.tlast} = b;
      in0_if.tvalid = busy[0];
    end
  endtask

  task automatic push_pkt(input bit s, input int len, input logic [BW-1:0] first);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data         = first + BW'(i);
      b.data[BW-1]   = s;
      b.keep         = KW'($urandom);
      b.id           = IW'($urandom);
      b.dest         = DW'($urandom);
      b.user         = UW'($urandom);
      b.last         = (i == len - 1);
      if (s) src1_q.push_back(b);
      else src0_q.push_back(b);
    end
  endtask

  task automatic update_sources();
    beat_t b;
    int    qs;
    for (int s = 0; s < 2; s++) begin
      if (acc[s]) begin
        if (s == 1) b = src1_q.pop_front();
        else b = src0_q.pop_front();
        busy[s] = 1'b0;
        if (b.last) beat_cnt[s] = 0;
        else begin
          beat_cnt[s]++;
          if (beat_cnt[s] == gap_at[s]) hold[s] = 2;
        end
      end
      qs = (s == 1) ? src1_q.size() : src0_q.size();
      if (!busy[s]) begin
        if (hold[s] > 0) hold[s]--;
        else if (qs != 0 && $urandom_range(99) < p_valid) busy[s] = 1'b1;
      end
      drive(s[0]);
    end
    acc = '0;
    out_if.tready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
  endtask

  task automatic check_cycle();
    bit    v0, v1, r0, r1, er0, er1;
    beat_t ob;
    beat_t ib;
    v0 = in0_if.tvalid;
    v1 = in1_if.tvalid;
    r0 = in0_if.tready;
    r1 = in1_if.tready;
    ob = out_beat();
    er0 = 1'b0;
    er1 = 1'b0;
    // The owner may push a beat when nothing is waiting downstream or it drains now.
    if (!m_free) begin
      if (m_owner) er1 = (m_q.size() == 0) || out_if.tready;
      else er0 = (m_q.size() == 0) || out_if.tready;
    end
    chk("in0_tready", 64'(r0), 64'(er0));
    chk("in1_tready", 64'(r1), 64'(er1));
    chk("out_tvalid", 64'(out_if.tvalid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) chk("out_beat", 64'(ob), 64'(m_q[0]));
    if (prev_stall) chk("out_stable", 64'({out_if.tvalid, ob}), 64'({1'b1, prev_out}));

    if (out_if.tvalid && out_if.tready) begin
      data_log.push_back(ob.data);
      fire_cyc.push_back(cyc);
      if (ob.last) pkt_log.push_back(int'(ob.data[BW-1]));
      if (m_q.size() != 0) void'(m_q.pop_front());
    end
    prev_stall = out_if.tvalid && !out_if.tready;
    prev_out   = ob;

    acc[0] = v0 && r0;
    acc[1] = v1 && r1;
    acc_total += int'(acc[0]) + int'(acc[1]);
    if (m_free) begin
      if (v0 || v1) begin
        m_owner = (v0 && v1) ? !m_last : v1;
        m_free  = 1'b0;
      end
    end else if (acc[m_owner]) begin
      ib = in_beat(m_owner);
      m_q.push_back(ib);
      if (ib.last) begin
        m_free = 1'b1;
        m_last = m_owner;
      end
    end
  endtask

  task automatic step();
    @(negedge aclk);
    check_cycle();
    cyc++;
    @(posedge aclk);
    #1;
    update_sources();
  endtask

  task automatic do_reset(input int n);
    aresetn = 1'b0;
    busy = '0;
    acc = '0;
    for (int s = 0; s < 2; s++) begin
      hold[s] = 0;
      beat_cnt[s] = 0;
      gap_at[s] = -1;
    end
    src0_q.delete();
    src1_q.delete();
    drive(1'b0);
    drive(1'b1);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      chk("rst_in0_tready", 64'(in0_if.tready), 64'd0);
      chk("rst_in1_tready", 64'(in1_if.tready), 64'd0);
      if (i > 0) begin
        chk("rst_out_tvalid", 64'(out_if.tvalid), 64'd0);
        chk("rst_out_fields", 64'(out_beat()), 64'd0);
      end
      @(posedge aclk);
      #1;
    end
    aresetn = 1'b1;
    m_free = 1'b1;
    m_last = 1'b1;
    m_q.delete();
    prev_stall = 1'b0;
    acc_total = 0;
    cyc = 0;
    pkt_log.delete();
    data_log.delete();
    fire_cyc.delete();
  endtask

  task automatic run_drain(input int max_cycles);
    int n;
    n = 0;
    while (!(src0_q.size() == 0 && src1_q.size() == 0 && m_q.size() == 0 && m_free)
           && n < max_cycles) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(n < max_cycles), 64'd1);
    step();
  endtask

  initial begin
    int exp_c[6];
    int total;
    int n;
    p_valid = 100;
    rand_ready = 1'b0;
    out_if.tready = 1'b1;
    do_reset(3);

    // Simultaneous requests: input 0 first at cycles 2..4, one bubble, then input 1.
    push_pkt(1'b0, 3, 32'h100);
    push_pkt(1'b1, 3, 32'h200);
    update_sources();
    run_drain(50);
    exp_c = '{2, 3, 4, 6, 7, 8};
    chk("s1_pkts", 64'(pkt_log.size()), 64'd2);
    chk("s1_first", 64'(pkt_log.size() > 0 ? pkt_log[0] : 9), 64'd0);
    chk("s1_fires", 64'(fire_cyc.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      chk("s1_fire_cycle", 64'(i < fire_cyc.size() ? fire_cyc[i] : -1), 64'(exp_c[i]));

    // Input 1 streaming; input 0 joins mid-packet and wins the next arbitration.
    do_reset(2);
    for (int k = 0; k < 4; k++) push_pkt(1'b1, 3, BW'(32'h300 + 16 * k));
    update_sources();
    step();
    step();
    push_pkt(1'b0, 3, 32'h400);
    run_drain(100);
    chk("s2_pkts", 64'(pkt_log.size()), 64'd5);
    chk("s2_first", 64'(pkt_log.size() > 0 ? pkt_log[0] : 9), 64'd1);
    chk("s2_second", 64'(pkt_log.size() > 1 ? pkt_log[1] : 9), 64'd0);

    // Granted input pauses two cycles mid-packet while input 1 waits.
    do_reset(2);
    gap_at[0] = 2;
    push_pkt(1'b0, 4, 32'h500);
    push_pkt(1'b1, 2, 32'h600);
    update_sources();
    run_drain(100);
    chk("s3_pkts", 64'(pkt_log.size()), 64'd2);
    chk("s3_first", 64'(pkt_log.size() > 0 ? pkt_log[0] : 9), 64'd0);
    chk("s3_beats", 64'(data_log.size()), 64'd6);

    // Random backpressure on an 8-beat packet carrying 1..8.
    do_reset(2);
    rand_ready = 1'b1;
    push_pkt(1'b0, 8, 32'h1);
    update_sources();
    run_drain(300);
    rand_ready = 1'b0;
    chk("s4_beats", 64'(data_log.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      chk("s4_data", 64'(i < data_log.size() ? data_log[i] : '1), 64'(i + 1));

    // Single-beat packets from both inputs alternate strictly.
    do_reset(2);
    for (int k = 0; k < 3; k++) begin
      push_pkt(1'b0, 1, BW'(32'h700 + k));
      push_pkt(1'b1, 1, BW'(32'h710 + k));
    end
    update_sources();
    run_drain(100);
    chk("s5_pkts", 64'(pkt_log.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      chk("s5_alt", 64'(i < pkt_log.size() ? pkt_log[i] : 9), 64'(i % 2));

    // Random traffic with source gaps and random backpressure.
    do_reset(2);
    p_valid = 60;
    rand_ready = 1'b1;
    total = 0;
    for (int k = 0; k < 30; k++) begin
      n = int'($urandom_range(5, 1));
      push_pkt(1'b0, n, BW'(k * 16));
      total += n;
      n = int'($urandom_range(5, 1));
      push_pkt(1'b1, n, BW'(k * 16 + 8));
      total += n;
    end
    update_sources();
    run_drain(5000);
    chk("s6_beats", 64'(data_log.size()), 64'(total));
    chk("s6_pkts", 64'(pkt_log.size()), 64'd60);
    p_valid = 100;
    rand_ready = 1'b0;

    // Reset pulsed while beat 2 of a 4-beat packet is in flight.
    do_reset(2);
    push_pkt(1'b0, 4, 32'h800);
    push_pkt(1'b1, 4, 32'h900);
    update_sources();
    n = 0;
    while (acc_total < 2 && n < 20) begin
      step();
      n++;
    end
    chk("s7_reach_beat2", 64'(acc_total), 64'd2);
    do_reset(2);
    push_pkt(1'b1, 2, 32'hA00);
    push_pkt(1'b0, 2, 32'hB00);
    update_sources();
    run_drain(100);
    chk("s7_pkts", 64'(pkt_log.size()), 64'd2);
    chk("s7_first", 64'(pkt_log.size() > 0 ? pkt_log[0] : 9), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/axi_stream_2_to_1_arbiter.md
AXI_STREAM_2_TO_1_ARBITER -- requirements
Module: axi_stream_2_to_1_arbiter

Interface
REQ-001 SHALL have parameter AXIS_BUS_WIDTH, default 64, tdata width in bits (multiple of 8).
REQ-002 SHALL have parameter AXIS_TID_WIDTH, default 1, tid width.
REQ-003 SHALL have parameter AXIS_TDEST_WIDTH, default 1, tdest width.
REQ-004 SHALL have parameter AXIS_TUSER_WIDTH, default 1, tuser width.
REQ-005 SHALL support only non-zero widths for all parameters.
REQ-006 SHALL have port aclk  in  1  clock; all interfaces synchronous to it.
REQ-007 SHALL have port aresetn  in  1  reset, synchronous, active-low.
REQ-008 SHALL have ports axis_in_#_tdata  in  AXIS_BUS_WIDTH  input data, # = 0,1.
REQ-009 SHALL have ports axis_in_#_tkeep  in  AXIS_BUS_WIDTH/8  byte enables.
REQ-010 SHALL have ports axis_in_#_tid / _tdest / _tuser  in  TID/TDEST/TUSER widths  sideband.
REQ-011 SHALL have ports axis_in_#_tlast, axis_in_#_tvalid  in  1  end-of-packet, valid.
REQ-012 SHALL have ports axis_in_#_tready  out  1  input accept.
REQ-013 SHALL have ports axis_out_tdata/tkeep/tid/tdest/tuser  out  same widths  merged stream.
REQ-014 SHALL have ports axis_out_tlast, axis_out_tvalid  out  1; axis_out_tready  in  1.

Function
REQ-015 SHALL merge two AXI streams into one, arbitrating per packet (grant held until a tlast beat is accepted), never interleaving beats of different packets.
REQ-016 SHALL implement a two-state FSM: IDLE (no grant) and LOCKED (grant held by input g).
REQ-017 IDLE: if exactly one axis_in_#_tvalid is high, SHALL register g = # and go LOCKED next cycle; if both high, SHALL grant the input not in last_served; if neither, stay IDLE.
REQ-018 In IDLE both axis_in_#_tready SHALL be 0; no beat is accepted in the arbitration cycle.
REQ-019 LOCKED: axis_in_g_tready = !axis_out_tvalid || axis_out_tready; the non-granted tready SHALL be 0.
REQ-020 Output register SHALL load the granted input's fields when (!axis_out_tvalid || axis_out_tready); axis_out_tvalid <= (LOCKED && axis_in_g_tvalid) at that load.
REQ-021 When axis_out_tvalid is high and axis_out_tready low, all axis_out_* SHALL hold stable.
REQ-022 On an accepted input beat (valid && ready) with tlast=1, SHALL set last_served <= g and return to IDLE next cycle.
REQ-023 Latency: first beat of a packet appears on axis_out 2 cycles after tvalid first seen in IDLE; subsequent beats 1 cycle after acceptance; back-to-back packets incur exactly one bubble cycle.
REQ-024 Deassertion of axis_in_g_tvalid mid-packet SHALL NOT release the grant.
REQ-025 Full throughput (one beat/cycle) SHALL be sustained within a packet when axis_out_tready stays high.
REQ-026 Single-beat packets (tlast on first beat) SHALL be supported: LOCKED for one acceptance, then IDLE.
REQ-027 Sideband fields SHALL pass through unmodified; no beat dropped, duplicated or reordered.

Reset
REQ-028 While aresetn=0: state IDLE, last_served=1 (input 0 wins first tie), axis_out_tvalid=0, all axis_out data/sideband/tlast=0, both axis_in_#_tready=0.
REQ-029 Reset mid-packet SHALL discard any registered beat and partial grant; after release, arbitration restarts from IDLE.

Verification
REQ-030 Both inputs valid simultaneously after reset, 3-beat packets, out_tready=1 -> input 0 packet out first (beats at cycles 2,3,4), input 1 packet follows after one bubble.
REQ-031 Input 1 continuously offering packets, input 0 offers one packet mid-stream -> after input 1's current tlast, input 0 is granted next; no interleaving.
REQ-032 Granted input drops tvalid for 2 cycles mid-packet while other input valid -> grant held, output resumes with same packet, other input tready stays 0.
REQ-033 out_tready toggled 1/0 randomly, 8-beat packet tdata 0x1..0x8 -> output order 0x1..0x8 exact, fields stable while stalled, tlast only on 0x8.
REQ-034 Single-beat packets alternating from both inputs -> strict alternation 0,1,0,1 on axis_out, each with tlast=1.
REQ-035 aresetn pulsed low during beat 2 of a 4-beat packet -> axis_out_tvalid=0 next cycle, both tready=0 during reset, fresh arbitration after release.
